// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - exhaustive truth-table scanner comparing two boolean expressions
//
// Walks every input vector 0..R-1 of an N-input boolean space, one row per
// clock. At each row it presents the values of two captured truth tables A and B.
// While it scans, it accumulates the number of rows where A is true, and it
// records the first row where A and B disagree.
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       request a scan (accepted only when idle)
//   abort       cancel a scan in progress
//   func_a      truth table of A, bit i = A(vector i)
//   func_b      truth table of B, same encoding
//   busy        scan in progress
//   vec_valid   vec/sa/sb present a row this cycle
//   vec         current input vector, MSB = first variable
//   sa, sb      A and B evaluated at vec
//   done        one-cycle pulse after the last row
//   ones_a      number of rows where A = 1
//   mismatch    some row had sa != sb
//   first_miss  lowest differing row (0 if none)
//   equal       A and B agree on every row (valid after done)

module truth_table_checker #(
    parameter  int N = 3,
    localparam int R = 1 << N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [R-1:0] func_a,
    input  logic [R-1:0] func_b,
    output logic         busy,
    output logic         vec_valid,
    output logic [N-1:0] vec,
    output logic         sa,
    output logic         sb,
    output logic         done,
    output logic [N:0]   ones_a,
    output logic         mismatch,
    output logic [N-1:0] first_miss,
    output logic         equal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   state;
    logic [N-1:0] row;
    logic [R-1:0] tab_a;
    logic [R-1:0] tab_b;

    logic in_scan;
    logic row_a;
    logic row_b;
    logic row_diff;
    logic last_row;

    assign in_scan  = (state == S_SCAN);
    assign row_a    = tab_a[row];
    assign row_b    = tab_b[row];
    assign row_diff = row_a ^ row_b;
    // Row counter is exactly N bits wide, so the final row is all ones.
    assign last_row = &row;

    // Row outputs are forced to 0 outside SCAN. This keeps stale table bits
    // from appearing when no row is valid.
    assign busy      = in_scan;
    assign vec_valid = in_scan;
    assign vec       = in_scan ? row : '0;
    assign sa        = in_scan & row_a;
    assign sb        = in_scan & row_b;
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            row        <= '0;
            tab_a      <= '0;
            tab_b      <= '0;
            ones_a     <= '0;
            mismatch   <= 1'b0;
            first_miss <= '0;
            equal      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // start wins over a simultaneous abort. abort has no
                    // effect here anyway.
                    if (start) begin
                        state      <= S_SCAN;
                        row        <= '0;
                        tab_a      <= func_a;
                        tab_b      <= func_b;
                        ones_a     <= '0;
                        mismatch   <= 1'b0;
                        first_miss <= '0;
                        equal      <= 1'b0;
                    end
                end

                S_SCAN: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        row        <= '0;
                        ones_a     <= '0;
                        mismatch   <= 1'b0;
                        first_miss <= '0;
                        equal      <= 1'b0;
                    end else begin
                        ones_a <= ones_a + (N+1)'(row_a);
                        // Only the first disagreement is recorded.
                        // Later ones leave first_miss alone.
                        if (row_diff && !mismatch) begin
                            mismatch   <= 1'b1;
                            first_miss <= row;
                        end
                        if (last_row) begin
                            state <= S_DONE;
                            row   <= '0;
                            // Fold in the final row's comparison. mismatch
                            // itself only updates at this same edge.
                            equal <= ~(mismatch | row_diff);
                        end else begin
                            row <= row + N'(1);
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - directed self-checking bench for truth_table_checker

module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] fa;
    logic [7:0] fb;
    logic       busy;
    logic       vec_valid;
    logic [2:0] vec;
    logic       sa;
    logic       sb;
    logic       done;
    logic [3:0] ones_a;
    logic       mismatch;
    logic [2:0] first_miss;
    logic       equal;

    logic       start1;
    logic       abort1;
    logic [1:0] fa1;
    logic [1:0] fb1;
    logic       busy1;
    logic       vec_valid1;
    logic [0:0] vec1;
    logic       sa1;
    logic       sb1;
    logic       done1;
    logic [1:0] ones_a1;
    logic       mismatch1;
    logic [0:0] first_miss1;
    logic       equal1;

    int checks   = 0;
    int passes   = 0;
    int done_cnt = 0;

    truth_table_checker #(.N(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .func_a(fa), .func_b(fb), .busy(busy), .vec_valid(vec_valid),
        .vec(vec), .sa(sa), .sb(sb), .done(done), .ones_a(ones_a),
        .mismatch(mismatch), .first_miss(first_miss), .equal(equal)
    );

    truth_table_checker #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .func_a(fa1), .func_b(fb1), .busy(busy1), .vec_valid(vec_valid1),
        .vec(vec1), .sa(sa1), .sb(sb1), .done(done1), .ones_a(ones_a1),
        .mismatch(mismatch1), .first_miss(first_miss1), .equal(equal1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; fa = 8'h00; fb = 8'h00;
        start1 = 1'b0; abort1 = 1'b0; fa1 = 2'b00; fb1 = 2'b00;
        #3;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0h exp=0", busy); else passes++;
        checks++; if (vec_valid !== 1'b0) $display("FAIL reset_vec_valid got=%0h exp=0", vec_valid); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0h exp=0", done); else passes++;
        checks++; if (ones_a !== 4'd0) $display("FAIL reset_ones_a got=%0h exp=0", ones_a); else passes++;
        checks++; if (mismatch !== 1'b0 || equal !== 1'b0) $display("FAIL reset_flags got=%0h%0h exp=00", mismatch, equal); else passes++;
        checks++; if (first_miss !== 3'd0 || vec !== 3'd0) $display("FAIL reset_idx got=%0h/%0h exp=0/0", first_miss, vec); else passes++;
        step; step;
        rst_n = 1'b1;
        step;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_idle got=%0h%0h exp=00", busy, done); else passes++;
    endtask

    task automatic run_scan(input logic [7:0] a, input logic [7:0] b, input logic [3:0] e_ones,
                            input logic e_mis, input logic [2:0] e_first, input logic disturb,
                            input string name);
        int d0;
        fa = a; fb = b; start = 1'b1;
        step;
        start = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            checks++; if (vec_valid !== 1'b1 || busy !== 1'b1) $display("FAIL %s_valid row=%0d got=%0h%0h exp=11", name, i, vec_valid, busy); else passes++;
            checks++; if (vec !== 3'(i)) $display("FAIL %s_vec got=%0d exp=%0d", name, vec, i); else passes++;
            checks++; if (sa !== a[i] || sb !== b[i]) $display("FAIL %s_sasb row=%0d got=%0h%0h exp=%0h%0h", name, i, sa, sb, a[i], b[i]); else passes++;
            checks++; if (done !== 1'b0) $display("FAIL %s_early_done row=%0d got=%0h exp=0", name, i, done); else passes++;
            if (disturb && i == 3) begin
                fa = ~fa; fb = ~fb; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step;
        end
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || vec_valid !== 1'b0) $display("FAIL %s_done got=%0h%0h%0h exp=100", name, done, busy, vec_valid); else passes++;
        checks++; if (ones_a !== e_ones) $display("FAIL %s_ones_a got=%0d exp=%0d", name, ones_a, e_ones); else passes++;
        checks++; if (mismatch !== e_mis) $display("FAIL %s_mismatch got=%0h exp=%0h", name, mismatch, e_mis); else passes++;
        checks++; if (first_miss !== e_first) $display("FAIL %s_first_miss got=%0d exp=%0d", name, first_miss, e_first); else passes++;
        checks++; if (equal !== ~e_mis) $display("FAIL %s_equal got=%0h exp=%0h", name, equal, ~e_mis); else passes++;
        if (disturb) start = 1'b1;
        step;
        start = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s_after got=%0h%0h exp=00", name, done, busy); else passes++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL %s_done_pulses got=%0d exp=1", name, done_cnt - d0); else passes++;
        checks++; if (ones_a !== e_ones || equal !== ~e_mis) $display("FAIL %s_hold got=%0d/%0h exp=%0d/%0h", name, ones_a, equal, e_ones, ~e_mis); else passes++;
    endtask

    task automatic test_equal;
        run_scan(8'h8A, 8'h8A, 4'd3, 1'b0, 3'd0, 1'b0, "equal");
    endtask

    task automatic test_mismatch;
        run_scan(8'h8A, 8'hAA, 4'd3, 1'b1, 3'd5, 1'b0, "mismatch");
    endtask

    task automatic test_boundary;
        run_scan(8'h00, 8'hFF, 4'd0, 1'b1, 3'd0, 1'b0, "zero");
        run_scan(8'hFF, 8'hFF, 4'd8, 1'b0, 3'd0, 1'b0, "full");
    endtask

    task automatic test_capture;
        run_scan(8'h8A, 8'hAA, 4'd3, 1'b1, 3'd5, 1'b1, "capture");
    endtask

    task automatic test_priority;
        abort = 1'b1;
        step;
        abort = 1'b0;
        checks++; if (equal !== 1'b0 || mismatch !== 1'b1 || first_miss !== 3'd5) $display("FAIL idle_abort got=%0h%0h/%0d exp=01/5", equal, mismatch, first_miss); else passes++;
        start = 1'b1; abort = 1'b1;
        step;
        checks++; if (busy !== 1'b1 || vec !== 3'd0) $display("FAIL prio_idle got=%0h/%0d exp=1/0", busy, vec); else passes++;
        step;
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || vec_valid !== 1'b0) $display("FAIL prio_scan got=%0h%0h exp=00", busy, vec_valid); else passes++;
        step;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL prio_settle got=%0h%0h exp=00", busy, done); else passes++;
    endtask

    task automatic test_abort;
        int d0;
        d0 = done_cnt;
        fa = 8'hFF; fb = 8'h00; start = 1'b1;
        step;
        start = 1'b0;
        repeat (4) step;
        checks++; if (vec !== 3'd4 || ones_a !== 4'd4 || mismatch !== 1'b1) $display("FAIL abort_pre got=%0d/%0d/%0h exp=4/4/1", vec, ones_a, mismatch); else passes++;
        abort = 1'b1;
        step;
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || vec_valid !== 1'b0 || done !== 1'b0) $display("FAIL abort_state got=%0h%0h%0h exp=000", busy, vec_valid, done); else passes++;
        checks++; if (ones_a !== 4'd0 || mismatch !== 1'b0 || first_miss !== 3'd0 || equal !== 1'b0) $display("FAIL abort_results got=%0d/%0h/%0d/%0h exp=0/0/0/0", ones_a, mismatch, first_miss, equal); else passes++;
        repeat (10) step;
        checks++; if (done_cnt !== d0 || busy !== 1'b0) $display("FAIL abort_no_done got=%0d/%0h exp=%0d/0", done_cnt, busy, d0); else passes++;
    endtask

    task automatic test_reset_mid;
        int d0;
        d0 = done_cnt;
        fa = 8'hFF; fb = 8'h00; start = 1'b1;
        step;
        start = 1'b0;
        step; step;
        checks++; if (vec !== 3'd2 || ones_a !== 4'd2) $display("FAIL rstmid_pre got=%0d/%0d exp=2/2", vec, ones_a); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || vec_valid !== 1'b0 || vec !== 3'd0 || sa !== 1'b0) $display("FAIL rstmid_async got=%0h%0h%0d%0h exp=0000", busy, vec_valid, vec, sa); else passes++;
        checks++; if (ones_a !== 4'd0 || mismatch !== 1'b0 || first_miss !== 3'd0) $display("FAIL rstmid_results got=%0d/%0h/%0d exp=0/0/0", ones_a, mismatch, first_miss); else passes++;
        step;
        rst_n = 1'b1;
        repeat (12) step;
        checks++; if (done_cnt !== d0 || busy !== 1'b0 || vec_valid !== 1'b0) $display("FAIL rstmid_idle got=%0d/%0h%0h exp=%0d/00", done_cnt, busy, vec_valid, d0); else passes++;
    endtask

    task automatic test_n1;
        fa1 = 2'b10; fb1 = 2'b11; start1 = 1'b1;
        step;
        start1 = 1'b0;
        checks++; if (vec_valid1 !== 1'b1 || vec1 !== 1'b0 || sa1 !== 1'b0 || sb1 !== 1'b1) $display("FAIL n1_row0 got=%0h%0h%0h%0h exp=1001", vec_valid1, vec1, sa1, sb1); else passes++;
        step;
        checks++; if (vec_valid1 !== 1'b1 || vec1 !== 1'b1 || sa1 !== 1'b1 || sb1 !== 1'b1) $display("FAIL n1_row1 got=%0h%0h%0h%0h exp=1111", vec_valid1, vec1, sa1, sb1); else passes++;
        step;
        checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) $display("FAIL n1_done got=%0h%0h exp=10", done1, busy1); else passes++;
        checks++; if (ones_a1 !== 2'd1 || mismatch1 !== 1'b1 || first_miss1 !== 1'b0 || equal1 !== 1'b0) $display("FAIL n1_results got=%0d/%0h/%0d/%0h exp=1/1/0/0", ones_a1, mismatch1, first_miss1, equal1); else passes++;
        step;
        checks++; if (done1 !== 1'b0) $display("FAIL n1_done_pulse got=%0h exp=0", done1); else passes++;
    endtask

    initial begin
        test_reset;
        test_equal;
        test_mismatch;
        test_boundary;
        test_capture;
        test_priority;
        test_abort;
        test_reset_mid;
        test_n1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter N, default 3, number of boolean inputs x..z (legal 1..8).
REQ-002 Derived constant R = 2^N, number of truth-table rows.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new scan; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of a scan in progress.
REQ-007 func_a  input  R  truth table of expression A; bit i = value for input vector i.
REQ-008 func_b  input  R  truth table of expression B, same encoding.
REQ-009 busy  output  1  high in SCAN.
REQ-010 vec_valid  output  1  high when vec/sa/sb present a row.
REQ-011 vec  output  N  current input vector, MSB = first variable (x).
REQ-012 sa  output  1  A evaluated at vec.
REQ-013 sb  output  1  B evaluated at vec.
REQ-014 done  output  1  one-cycle pulse at scan completion.
REQ-015 ones_a  output  N+1  count of rows where A = 1.
REQ-016 mismatch  output  1  at least one row with sa != sb.
REQ-017 first_miss  output  N  lowest row index with sa != sb; 0 if none.
REQ-018 equal  output  1  A and B identical over all R rows; valid after done.

Function
REQ-019 FSM states IDLE, SCAN, DONE; IDLE -> SCAN on start; SCAN -> DONE after row R-1; DONE -> IDLE unconditionally after one cycle.
REQ-020 On start accepted in IDLE, func_a/func_b are captured into internal registers; input changes after capture do not affect the scan.
REQ-021 On start accepted, ones_a, mismatch, first_miss, equal clear to 0 in the same edge.
REQ-022 Latency: start high at edge t -> rows 0..R-1 presented with vec_valid=1 on cycles t+1..t+R; done=1 on cycle t+R+1.
REQ-023 In SCAN, row index increments by 1 per cycle, 0 to R-1 in ascending order, no gaps; no wrap within a scan.
REQ-024 sa/sb = captured table bit at index vec; vec, sa, sb valid only while vec_valid=1, else vec=0, sa=sb=0.
REQ-025 ones_a accumulates sa per row; width N+1 holds maximum R without overflow.
REQ-026 mismatch sets on first row with sa != sb and stays set; first_miss loads that row index only on the first mismatch, later mismatches ignored.
REQ-027 equal = ~mismatch, registered on the SCAN -> DONE transition; held, together with ones_a/mismatch/first_miss, until next accepted start or reset.
REQ-028 start while busy or in DONE is ignored (no restart, no queuing).
REQ-029 abort in SCAN: return to IDLE next edge, no done pulse, results cleared to 0; abort in IDLE/DONE has no effect.
REQ-030 abort and start high together in IDLE: start wins; in SCAN: abort wins.
REQ-031 N=1 supported: R=2, scan lasts 2 cycles.

Reset
REQ-032 rst_n low forces state IDLE immediately, independent of clk, and clears every output to 0 and internal table registers to 0.
REQ-033 Reset asserted mid-scan aborts it with no done pulse; after release, block idles until a new start.

Verification (N=3, vec = {x,y,z})
REQ-034 func_a=8'h8A ((x.y')'.z), func_b=8'h8A, start -> rows 0..7 over 8 cycles, sa=0,1,0,1,0,0,0,1; done at t+9; ones_a=3, mismatch=0, equal=1.
REQ-035 func_a=8'h8A, func_b=8'hAA (z) -> mismatch=1, first_miss=5, ones_a=3, equal=0.
REQ-036 func_a=8'h00, func_b=8'hFF -> first_miss=0, ones_a=0; func_a=8'hFF -> ones_a=8 (no overflow).
REQ-037 Toggle func_a and pulse start during SCAN -> results match captured table, single done pulse, no restart.
REQ-038 abort at row 4 -> IDLE next cycle, done never pulses, all results 0; rst_n low at row 2 -> outputs 0 asynchronously, no done.
